byte_data_memory: RTL and testbench

Parametrised, byte-addressed data memory for the RISC-V core's load/store path, replacing the fixed 32-word, word-only, combinational-read memory. It supports LB/LH/LW/LBU/LHU and SB/SH/SW with little-endian byte lanes and sign/zero extension. Requests use a valid/ready handshake with a registered one-cycle response, and errors are flagged for misaligned, out-of-range and illegal accesses. After every reset a self-initialisation sequencer fills memory with a deterministic pattern before accepting requests.

---
 rtl/byte_data_memory.sv | 237 +++++++++++++++++++++++
 tb/tb_byte_data_memory.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_data_memory.sv
// byte_data_memory
//
// Byte-addressed data memory for the RISC-V load/store path. It serves
// LB/LH/LW/LBU/LHU and SB/SH/SW with little-endian byte lanes and
// sign/zero extension. Requests use a valid/ready handshake. Each accepted
// request gets exactly one registered response one cycle later.
// After every reset a sequencer fills word i with i*INIT_STEP.
// Requests are accepted only after that fill completes.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   ADDR_W       request byte-address width
//   INIT_STEP    word i initialises to i*INIT_STEP (mod 2^32)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; restarts initialisation
//   req_valid    request present
//   req_ready    block can accept a request this cycle (IDLE only)
//   req_we       1 = store, 0 = load
//   req_funct3   RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   req_addr     byte address
//   req_wdata    store data, low-aligned (byte [7:0], half [15:0])
//   rsp_valid    one-cycle response strobe
//   rsp_rdata    formatted load data (0 for stores and errors)
//   rsp_err      request rejected: misaligned, out of range or illegal funct3
//   init_busy    initialisation in progress
module byte_data_memory #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          ADDR_W      = 32,
  parameter int unsigned INIT_STEP   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] init_ptr_reg;
  // Running value init_ptr*INIT_STEP, kept as an accumulator so no multiplier is needed.
  logic [31:0]      init_val_reg;
  logic             req_ready_reg;
  logic             rsp_valid_reg;
  logic [31:0]      rsp_rdata_reg;
  logic             rsp_err_reg;
  logic             init_busy_reg;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [1:0]       req_lane;
  logic [IDX_W-1:0] req_idx;
  logic             out_of_range;
  logic             misaligned;
  logic             illegal_funct3;
  logic             req_err;
  logic             accept;
  logic             store_commit;

  assign req_lane     = req_addr[1:0];
  assign req_idx      = req_addr[IDX_W+1:2];
  assign out_of_range = (req_addr >= ADDR_LIMIT);

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    if (req_we) begin
      // Stores have no unsigned variants: only 0..2 are legal.
      illegal_funct3 = (req_funct3 > 3'd2);
    end else begin
      // Loads reject 3, 6 and 7. funct3[1:0] == 3 covers both 3 and 7.
      illegal_funct3 = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'd6);
    end
  end

  assign req_err      = out_of_range | misaligned | illegal_funct3;
  assign accept       = req_ready_reg & req_valid;
  assign store_commit = accept & req_we & ~req_err;

  // ---------------------------------------------------------------------------
  // Memory write port: shared by the init sequencer and committed stores.
  // Stores replicate their data across lanes so that each lane only needs an
  // enable, which maps onto byte-enable RAM.
  // ---------------------------------------------------------------------------
  logic [3:0]       lane_we;
  logic [31:0]      lane_wdata;
  logic [IDX_W-1:0] wr_idx;

  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = req_wdata;
    wr_idx     = req_idx;
    if (state_reg == ST_INIT) begin
      lane_we    = 4'b1111;
      lane_wdata = init_val_reg;
      wr_idx     = init_ptr_reg;
    end else if (store_commit) begin
      case (req_funct3[1:0])
        2'd0: begin
          lane_we    = 4'b0001 << req_lane;
          lane_wdata = {4{req_wdata[7:0]}};
        end
        2'd1: begin
          lane_we    = req_addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          lane_we    = 4'b1111;
          lane_wdata = req_wdata;
        end
      endcase
    end
  end

  // One byte-wide array per lane; reads are asynchronous because the load
  // word has to be formatted into the response register at acceptance.
  logic [31:0] rd_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        mem[wr_idx] <= lane_wdata[8*gi +: 8];
      end
    end

    assign rd_word[8*gi +: 8] = mem[req_idx];
  end

  // ---------------------------------------------------------------------------
  // Load formatting
  // ---------------------------------------------------------------------------
  logic [31:0] lane_shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign lane_shifted = rd_word >> {req_lane, 3'b000};
  assign byte_sel     = lane_shifted[7:0];
  assign half_sel     = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (req_funct3)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'd0, byte_sel};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      init_ptr_reg  <= '0;
      init_val_reg  <= 32'd0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
      init_busy_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_INIT: begin
          init_ptr_reg <= init_ptr_reg + 1'b1;
          init_val_reg <= init_val_reg + INIT_STEP;
          if (init_ptr_reg == LAST_IDX) begin
            state_reg     <= ST_IDLE;
            init_busy_reg <= 1'b0;
            req_ready_reg <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            state_reg     <= ST_RESP;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= req_err;
            // Stores and rejected requests return zero data.
            rsp_rdata_reg <= (req_err || req_we) ? 32'd0 : load_data;
          end
        end
        ST_RESP: begin
          state_reg     <= ST_IDLE;
          rsp_valid_reg <= 1'b0;
          req_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= ST_INIT;
          init_ptr_reg  <= '0;
          init_val_reg  <= 32'd0;
          req_ready_reg <= 1'b0;
          rsp_valid_reg <= 1'b0;
          init_busy_reg <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign init_busy = init_busy_reg;

endmodule

// File: tb/tb_byte_data_memory.sv
// Testbench for byte_data_memory: directed cases from the test plan plus
// randomized requests, all checked against a byte-array reference model.
module tb_byte_data_memory;

  localparam int DEPTH_WORDS = 64;
  localparam int ADDR_W      = 32;
  localparam int MEM_BYTES   = DEPTH_WORDS * 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  byte_data_memory #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W),
    .INIT_STEP  (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] model_mem [MEM_BYTES];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference memory: word i holds i*20, stored little-endian as bytes.
  task automatic model_init();
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      logic [31:0] w;
      w = 32'(i * 20);
      for (int k = 0; k < 4; k++) model_mem[4*i+k] = 8'(w >> (8*k));
    end
  endtask

  function automatic void model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic [31:0] rdata,
                                       output logic err);
    int size;
    logic [63:0] val;
    logic illegal;
    size    = 1 << f3[1:0];
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    err     = (addr >= 32'(MEM_BYTES)) || illegal || ((addr % size) != 0);
    rdata   = 32'd0;
    if (err) return;
    if (we) begin
      for (int k = 0; k < size; k++) model_mem[int'(addr)+k] = 8'(wdata >> (8*k));
    end else begin
      val = 64'd0;
      for (int k = 0; k < size; k++) val = val | (64'(model_mem[int'(addr)+k]) << (8*k));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((64'd1 << (8*size)) - 64'd1);
      rdata = val[31:0];
    end
  endfunction

  // Counts init_busy cycles starting at the negedge where reset is released.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_value({tag, " init cycles"}, 32'(n), 32'd64);
    check_value({tag, " ready after init"}, {31'd0, req_ready}, 32'd1);
  endtask

  // One request, called at a negedge; returns at the negedge after the response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag,
                        output logic [31:0] got, output logic got_err);
    logic [31:0] exp_d;
    logic        exp_e;
    int          waited;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    waited     = 0;
    got        = 32'd0;
    got_err    = 1'b0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check_value({tag, " ready timeout"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    model_access(we, f3, addr, wdata, exp_d, exp_e);
    @(negedge clk);
    req_valid = 1'b0;
    got       = rsp_rdata;
    got_err   = rsp_err;
    $display("%s: we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d",
             tag, we, f3, addr, wdata, rsp_rdata, rsp_err);
    check_value({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_value({tag, " rdata"}, rsp_rdata, exp_d);
    check_value({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_e});
    check_value({tag, " ready in resp"}, {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check_value({tag, " rsp_valid drop"}, {31'd0, rsp_valid}, 32'd0);
    check_value({tag, " rdata hold"}, rsp_rdata, exp_d);
    check_value({tag, " ready back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [2:0]  b2b_f3 [4];
    logic [31:0] b2b_addr [4];
    logic [31:0] exp_dq [$];
    logic        exp_eq [$];
    int          acc_cyc [$];
    int          rsp_cyc [$];
    int          issued, responded, cyc;
    logic        advance;

    // ---------------- reset values ----------------
    #2 reset = 1'b1;
    #1;
    check_value("reset req_ready", {31'd0, req_ready}, 32'd0);
    check_value("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_value("reset rsp_rdata", rsp_rdata, 32'd0);
    check_value("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    check_value("reset init_busy", {31'd0, init_busy}, 32'd1);
    model_init();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_init("boot");

    // ---------------- first load ----------------
    do_req(1'b0, 3'd2, 32'h14, 32'd0, "lw_0x14", d, e);
    check_value("lw_0x14 value", d, 32'h0000_0064);

    // ---------------- load formatting ----------------
    do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, "sw_0x10", d, e);
    do_req(1'b0, 3'd0, 32'h13, 32'd0, "lb_0x13", d, e);
    check_value("lb_0x13 value", d, 32'hFFFF_FFDE);
    do_req(1'b0, 3'd4, 32'h13, 32'd0, "lbu_0x13", d, e);
    check_value("lbu_0x13 value", d, 32'h0000_00DE);
    do_req(1'b0, 3'd1, 32'h10, 32'd0, "lh_0x10", d, e);
    check_value("lh_0x10 value", d, 32'hFFFF_BEEF);
    do_req(1'b0, 3'd5, 32'h12, 32'd0, "lhu_0x12", d, e);
    check_value("lhu_0x12 value", d, 32'h0000_DEAD);

    // ---------------- byte / half stores ----------------
    do_req(1'b1, 3'd0, 32'h21, 32'h0000_00AA, "sb_0x21", d, e);
    do_req(1'b0, 3'd2, 32'h20, 32'd0, "lw_0x20_a", d, e);
    check_value("sb lane value", d, 32'h0000_AAA0);
    do_req(1'b1, 3'd1, 32'h22, 32'h0000_1234, "sh_0x22", d, e);
    do_req(1'b0, 3'd2, 32'h20, 32'd0, "lw_0x20_b", d, e);
    check_value("sh lane value", d, 32'h1234_AAA0);

    // ---------------- errors ----------------
    do_req(1'b0, 3'd2, 32'h02, 32'd0, "lw_misaligned", d, e);
    check_value("lw_misaligned err", {31'd0, e}, 32'd1);
    do_req(1'b1, 3'd1, 32'h01, 32'hFFFF_FFFF, "sh_misaligned", d, e);
    check_value("sh_misaligned err", {31'd0, e}, 32'd1);
    do_req(1'b0, 3'd2, 32'h00, 32'd0, "lw_0x00", d, e);
    check_value("lw_0x00 unchanged", d, 32'h0000_0000);
    do_req(1'b0, 3'd2, 32'h100, 32'd0, "lw_out_of_range", d, e);
    check_value("lw_out_of_range err", {31'd0, e}, 32'd1);
    do_req(1'b0, 3'd3, 32'h00, 32'd0, "load_f3_3", d, e);
    check_value("load_f3_3 err", {31'd0, e}, 32'd1);
    do_req(1'b1, 3'd4, 32'h00, 32'h5555_5555, "store_f3_4", d, e);
    check_value("store_f3_4 err", {31'd0, e}, 32'd1);

    // ---------------- back-to-back handshake ----------------
    b2b_f3[0] = 3'd2; b2b_addr[0] = 32'h10;
    b2b_f3[1] = 3'd4; b2b_addr[1] = 32'h21;
    b2b_f3[2] = 3'd1; b2b_addr[2] = 32'h22;
    b2b_f3[3] = 3'd2; b2b_addr[3] = 32'(4 * $urandom_range(0, DEPTH_WORDS - 1));
    issued = 0; responded = 0; cyc = 0; advance = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = b2b_f3[0];
    req_addr   = b2b_addr[0];
    while (responded < 4 && cyc < 40) begin
      if (rsp_valid) begin
        responded++;
        rsp_cyc.push_back(cyc);
        if (exp_dq.size() > 0) begin
          check_value("b2b rdata", rsp_rdata, exp_dq.pop_front());
          check_value("b2b err", {31'd0, rsp_err}, {31'd0, exp_eq.pop_front()});
        end else begin
          check_value("b2b unexpected rsp", 32'(responded), 32'(issued));
        end
        $display("b2b rsp %0d at cycle %0d: rdata=0x%08h err=%0d", responded, cyc, rsp_rdata, rsp_err);
      end
      if (advance) begin
        advance = 1'b0;
        if (issued < 4) begin
          req_funct3 = b2b_f3[issued];
          req_addr   = b2b_addr[issued];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc.push_back(cyc);
        model_access(1'b0, req_funct3, req_addr, 32'd0, d, e);
        exp_dq.push_back(d);
        exp_eq.push_back(e);
        issued++;
        advance = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    check_value("b2b issued", 32'(issued), 32'd4);
    check_value("b2b responded", 32'(responded), 32'd4);
    check_value("b2b extra rsp", {31'd0, rsp_valid}, 32'd0);
    if (acc_cyc.size() == 4 && rsp_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_value("b2b rsp latency", 32'(rsp_cyc[i] - acc_cyc[i]), 32'd1);
        if (i > 0) begin
          check_value("b2b accept spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
          check_value("b2b rsp spacing", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd2);
        end
      end
    end
    @(negedge clk);

    // ---------------- randomized traffic ----------------
    for (int t = 0; t < 300; t++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          r;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'(MEM_BYTES + $urandom_range(0, 15));
      else             addr = 32'($urandom_range(0, MEM_BYTES - 1));
      if (r >= 5) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      do_req(we, f3, addr, $urandom, $sformatf("rnd%0d", t), d, e);
    end

    // ---------------- reset during RESP of a store ----------------
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h40;
    req_wdata  = 32'hFFFF_FFFF;
    begin
      int waited;
      waited = 0;
      while (!req_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
    end
    check_value("midreset ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_value("midreset in resp", {31'd0, rsp_valid}, 32'd1);
    reset = 1'b1;
    #1;
    req_valid = 1'b0;
    check_value("midreset rsp_valid drop", {31'd0, rsp_valid}, 32'd0);
    check_value("midreset init_busy", {31'd0, init_busy}, 32'd1);
    check_value("midreset req_ready", {31'd0, req_ready}, 32'd0);
    model_init();
    @(negedge clk);
    reset = 1'b0;
    wait_init("midreset");
    do_req(1'b0, 3'd2, 32'h40, 32'd0, "lw_0x40_after_reset", d, e);
    check_value("lw_0x40 value", d, 32'h0000_0140);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
